// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: address/count width
// helpers and the hardwired-zero register index.
package regfile_pkg;

  localparam int unsigned ZERO_REG = 0;

  function automatic int unsigned addr_w(input int unsigned num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/regfile_sb_counter.sv
// Per-register pending-write counter: saturating up/down with simultaneous
// inc/dec netting to no change.
module regfile_sb_counter
  import regfile_pkg::*;
#(
  parameter  int unsigned MAX_PENDING = 3,
  localparam int unsigned CNT_W       = cnt_w(MAX_PENDING)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  logic             inc_ok;
  logic             dec_ok;
  logic [CNT_W-1:0] count_nxt;

  assign at_max = (count == CNT_W'(MAX_PENDING));

  // Never wrap: decrement only from nonzero, increment at max only if a retire frees a slot
  always_comb begin
    dec_ok    = dec && (count != '0);
    inc_ok    = inc && (!at_max || dec_ok);
    count_nxt = count + CNT_W'(inc_ok) - CNT_W'(dec_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/regfile_scoreboard_bypass.sv
// Multi-port register file with same-cycle write bypass, hardwired-zero r0 and
// a per-register pending-write scoreboard for RAW hazard detection at decode.
module regfile_scoreboard_bypass
  import regfile_pkg::*;
#(
  parameter  int unsigned WORD_SIZE   = 32,
  parameter  int unsigned NUM_REGS    = 32,
  parameter  int unsigned NUM_READ    = 2,
  parameter  int unsigned MAX_PENDING = 3,
  localparam int unsigned ADDR_W      = addr_w(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_rd,
  input  logic [WORD_SIZE-1:0]          wr_data,
  input  logic [NUM_READ*ADDR_W-1:0]    rd_addr,
  output logic [NUM_READ*WORD_SIZE-1:0] rd_data,
  output logic [NUM_READ-1:0]           rd_busy,
  input  logic                          sb_set,
  input  logic [ADDR_W-1:0]             sb_rd,
  output logic                          sb_ready,
  output logic                          err
);

  localparam int unsigned CNT_W = cnt_w(MAX_PENDING);

  logic [WORD_SIZE-1:0]             mem [NUM_REGS];
  logic [NUM_REGS-1:0][CNT_W-1:0]   pend;
  logic [NUM_REGS-1:0]              at_max;
  logic [NUM_REGS-1:0]              dec_vec;
  logic [NUM_REGS-1:0]              inc_vec;
  logic                             wr_nz;

  assign wr_nz = wr_en && (wr_rd != ADDR_W'(ZERO_REG));

  // A full counter still accepts an issue when the same cycle retires one of its writes
  assign sb_ready = !((sb_rd != ADDR_W'(ZERO_REG)) && at_max[sb_rd] && !dec_vec[sb_rd]);

  assign pend[0]    = '0;
  assign at_max[0]  = 1'b0;
  assign dec_vec[0] = 1'b0;
  assign inc_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    assign dec_vec[r] = wr_en && (wr_rd == ADDR_W'(r)) && (pend[r] != '0);
    assign inc_vec[r] = sb_set && sb_ready && (sb_rd == ADDR_W'(r));

    regfile_sb_counter #(
      .MAX_PENDING (MAX_PENDING)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc_vec[r]),
      .dec    (dec_vec[r]),
      .count  (pend[r]),
      .at_max (at_max[r])
    );
  end

  // Read ports: bypass the in-flight writeback; busy if writes remain after this retire
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[p*ADDR_W +: ADDR_W];
    assign rd_data[p*WORD_SIZE +: WORD_SIZE] =
      (wr_nz && (wr_rd == a)) ? wr_data : mem[a];
    assign rd_busy[p] = (pend[a] != CNT_W'(dec_vec[a]));
  end

  // r0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_nz) begin
      mem[wr_rd] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (wr_nz && (pend[wr_rd] == '0)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard_bypass.sv
// Bench for regfile_scoreboard_bypass: array/integer reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_regfile_scoreboard_bypass;

  localparam int unsigned W   = 32;
  localparam int unsigned NR  = 32;
  localparam int unsigned NRD = 2;
  localparam int unsigned MP  = 3;
  localparam int unsigned AW  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_rd;
  logic [W-1:0]     wr_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*W-1:0] rd_data;
  logic [NRD-1:0]   rd_busy;
  logic             sb_set;
  logic [AW-1:0]    sb_rd;
  logic             sb_ready;
  logic             err;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] m_mem [NR];
  int           m_pend [NR];
  bit           m_err;

  always #5 clk = ~clk;

  regfile_scoreboard_bypass #(
    .WORD_SIZE   (W),
    .NUM_REGS    (NR),
    .NUM_READ    (NRD),
    .MAX_PENDING (MP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_rd    (wr_rd),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .sb_set   (sb_set),
    .sb_rd    (sb_rd),
    .sb_ready (sb_ready),
    .err      (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Model: a write retiring on register a this cycle, if any are outstanding
  function automatic bit m_retire(input logic [AW-1:0] a);
    return wr_en && (a != 0) && (wr_rd == a) && (m_pend[a] > 0);
  endfunction

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_rd == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return (m_pend[a] - int'(m_retire(a))) != 0;
  endfunction

  function automatic bit exp_ready();
    if (sb_rd == 0) return 1'b1;
    return !(m_pend[sb_rd] == MP && !m_retire(sb_rd));
  endfunction

  // Reference state advance at each clock edge
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_mem[r]  <= '0;
        m_pend[r] <= 0;
      end
      m_err <= 1'b0;
    end else begin
      if (wr_en && wr_rd != 0) begin
        m_mem[wr_rd] <= wr_data;
        if (m_pend[wr_rd] == 0) m_err <= 1'b1;
      end
      for (int r = 1; r < NR; r++) begin
        m_pend[r] <= m_pend[r]
                   + int'(sb_set && exp_ready() && sb_rd == AW'(r))
                   - int'(m_retire(AW'(r)));
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NRD; p++) begin
        check("mdl_rd_data", 64'(rd_data[p*W +: W]), 64'(exp_rd(rd_addr[p*AW +: AW])));
        check("mdl_rd_busy", 64'(rd_busy[p]), 64'(exp_busy(rd_addr[p*AW +: AW])));
      end
      check("mdl_sb_ready", 64'(sb_ready), 64'(exp_ready()));
      check("mdl_err", 64'(err), 64'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_rd = '0; wr_data = '0;
    sb_set = 1'b0; sb_rd = '0; rd_addr = '0;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state on addresses 0, 5, 31
    set_rd(5'd0, 5'd5);
    #2;
    check("rst_rd_p0", 64'(rd_data[31:0]), 64'd0);
    check("rst_rd_p1", 64'(rd_data[63:32]), 64'd0);
    check("rst_busy", 64'(rd_busy), 64'd0);
    check("rst_ready", 64'(sb_ready), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    step();
    set_rd(5'd31, 5'd31);
    #2;
    check("rst_rd31", 64'(rd_data), 64'd0);

    // Bypass and r0 writes
    step();
    wr_en = 1'b1; wr_rd = 5'd5; wr_data = 32'hDEADBEEF;
    set_rd(5'd5, 5'd0);
    #2;
    check("bypass_rd5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    step();
    wr_en = 1'b0;
    #2;
    check("stored_rd5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("underflow_err_r5", 64'(err), 64'd1);
    wr_en = 1'b1; wr_rd = 5'd0; wr_data = 32'h1234;
    set_rd(5'd0, 5'd0);
    #2;
    check("r0_bypass_blocked", 64'(rd_data), 64'd0);
    step();
    wr_en = 1'b0;
    #2;
    check("r0_reads_zero", 64'(rd_data), 64'd0);
    do_reset();
    #2;
    check("err_cleared", 64'(err), 64'd0);

    // Saturate reg 7, then retire-and-issue in the same cycle
    sb_set = 1'b1; sb_rd = 5'd7;
    set_rd(5'd7, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #2;
      check("fill_ready", 64'(sb_ready), 64'd1);
      step();
    end
    #2;
    check("full_busy", 64'(rd_busy[0]), 64'd1);
    check("full_not_ready", 64'(sb_ready), 64'd0);
    wr_en = 1'b1; wr_rd = 5'd7; wr_data = 32'h77;
    #2;
    check("full_retire_ready", 64'(sb_ready), 64'd1);
    check("full_retire_busy", 64'(rd_busy[0]), 64'd1);
    check("full_retire_rd", 64'(rd_data[31:0]), 64'h77);
    step();
    wr_en = 1'b0;
    #2;
    check("still_full", 64'(sb_ready), 64'd0);
    sb_set = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 32'h70 + 32'(i);
      step();
    end
    wr_en = 1'b0;
    #2;
    check("drained_busy", 64'(rd_busy[0]), 64'd0);
    check("drained_rd", 64'(rd_data[31:0]), 64'h72);
    check("drained_err", 64'(err), 64'd0);

    // Last pending write retires: non-busy and bypassed in the same cycle
    step();
    sb_set = 1'b1; sb_rd = 5'd9;
    step();
    sb_set = 1'b0;
    set_rd(5'd0, 5'd9);
    #2;
    check("r9_busy", 64'(rd_busy[1]), 64'd1);
    wr_en = 1'b1; wr_rd = 5'd9; wr_data = 32'h55;
    #2;
    check("r9_retire_busy", 64'(rd_busy[1]), 64'd0);
    check("r9_retire_rd", 64'(rd_data[63:32]), 64'h55);
    step();
    wr_en = 1'b0;
    #2;
    check("r9_after_busy", 64'(rd_busy[1]), 64'd0);
    check("r9_after_err", 64'(err), 64'd0);

    // Underflow on reg 12 is sticky
    wr_en = 1'b1; wr_rd = 5'd12; wr_data = 32'hC0FFEE;
    step();
    wr_en = 1'b0;
    set_rd(5'd12, 5'd12);
    #2;
    check("r12_written", 64'(rd_data[31:0]), 64'hC0FFEE);
    check("r12_err", 64'(err), 64'd1);
    check("r12_not_busy", 64'(rd_busy), 64'd0);

    // Sweep writes over all registers with overlapping reads
    for (int r = 1; r < NR; r++) begin
      wr_en = 1'b1; wr_rd = AW'(r); wr_data = 32'h01010101 * 32'(r);
      set_rd(AW'(r), AW'(r - 1));
      step();
    end
    wr_en = 1'b0;
    set_rd(5'd31, 5'd30);
    #2;
    check("sweep_r31", 64'(rd_data[31:0]), 64'h1F1F1F1F);
    check("sweep_r30", 64'(rd_data[63:32]), 64'h1E1E1E1E);
    check("sweep_err_sticky", 64'(err), 64'd1);

    // Reset drops in-flight scoreboard state and the issue in the reset cycle
    do_reset();
    sb_set = 1'b1; sb_rd = 5'd3;
    step();
    step();
    sb_set = 1'b0;
    set_rd(5'd3, 5'd3);
    wr_en = 1'b1; wr_rd = 5'd3; wr_data = 32'hABCD;
    step();
    wr_en = 1'b0;
    #2;
    check("r3_pending_busy", 64'(rd_busy), 64'd3);
    check("r3_data", 64'(rd_data[31:0]), 64'hABCD);
    rst = 1'b1; sb_set = 1'b1; sb_rd = 5'd3;
    step();
    rst = 1'b0; sb_set = 1'b0;
    #2;
    check("post_rst_busy", 64'(rd_busy), 64'd0);
    check("post_rst_rd", 64'(rd_data), 64'd0);
    check("post_rst_ready", 64'(sb_ready), 64'd1);
    check("post_rst_err", 64'(err), 64'd0);
    step();
    step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
